serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
//   Wraps the team's single-bit full_subtractor cell with operand shift registers and a borrow flop.
//   Sits in the arithmetic datapath where area matters more than latency; start/done handshake to the controller.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range 1..64
// PORTS
//   clk     in   1      single clock; all state changes on rising edge
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      request; sampled only in IDLE
//   a       in   WIDTH  minuend; captured on accepted start
//   b       in   WIDTH  subtrahend; captured on accepted start
//   bin     in   1      borrow-in; captured on accepted start, seeds borrow flop
//   busy    out  1      1 while in RUN
//   done    out  1      one-cycle pulse; diff/bout valid from this cycle
//   diff    out  WIDTH  result, held until next accepted start
//   bout    out  1      final borrow-out (1 = a < b + bin), held with diff
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, busy=0, done=0, diff=0, bout=0, count=0, shift regs=0.
//   FSM states IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE), both decoded from registered state.
//   IDLE: start=1 at edge k -> load a_sh=a, b_sh=b, brw=bin, count=0; go RUN (busy=1 after edge k).
//   RUN: each edge, cell inputs a_sh[0], b_sh[0], brw; diff bit shifted in at MSB of res_sh,
//     a_sh/b_sh shift right, brw <= cell bout, count++. Edges k+1..k+WIDTH process bits 0..WIDTH-1.
//   At edge k+WIDTH (count==WIDTH-1): diff <= final res_sh, bout <= final borrow, go DONE.
//   DONE: done=1 for exactly one cycle, then IDLE unconditionally.
//   Latency: done high in the cycle following edge k+WIDTH; restart earliest at edge k+WIDTH+2.
//   start in RUN or DONE is ignored (no queueing, no error); a,b,bin are don't-care outside accepted start.
//   diff/bout change only at the RUN->DONE edge; stable otherwise (incl. during next RUN).
//   Arithmetic: modulo 2^WIDTH; diff = (a - b - bin) mod 2^WIDTH; bout = borrow out of bit WIDTH-1.
//   count width = $clog2(WIDTH+1) so WIDTH=1 is legal (1 RUN cycle).
//   Reset asserted mid-RUN/DONE: immediate return to reset values; no done pulse for aborted op.
//   X on start while in IDLE is a bench error; design need not guard it.
// STRUCTURE
//   serial_arith_defs.vh: localparam state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
//     shared with the planned serial_adder.
//   One sub-module instance: full_subtractor (u_fs) as the per-bit cell; no other hierarchy.
//   Single always block for FSM + datapath regs; cell outputs are the only combinational path.
// TESTING (WIDTH=8 unless noted)
//   1. a=5, b=3, bin=0, start 1 cycle -> busy 8 cycles, done pulse at edge+9 cycle, diff=8'h02, bout=0.
//   2. a=3, b=5, bin=0 -> diff=8'hFE, bout=1; a=0, b=0, bin=1 -> diff=8'hFF, bout=1.
//   3. a=8'hFF, b=8'h00, bin=0 then immediately a=8'h80, b=8'h80, bin=0 at earliest restart
//      -> 8'hFF/0 then 8'h00/0; done pulses exactly 10 cycles apart.
//   4. start held high with changing a/b during RUN -> ignored; result uses first captured a/b; one done.
//   5. rst_n low at RUN cycle 4 -> busy=0, diff=0, bout=0 asynchronously; no done; next op correct.
//   6. WIDTH=1: a=0, b=1, bin=0 -> diff=1, bout=1 after 1 RUN cycle; random 1000-op compare vs a-b-bin.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// The state encodings are also used by the planned serial adder.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } serialState_e;

    // Bit counter width.  The +1 keeps WIDTH=1 at a legal, non-zero width.
    function automatic int cntWidth(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// Single-bit full subtractor cell: diff = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic diff_o,
    output logic bout_o
);

    assign diff_o = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Handshake: start accepted in IDLE, busy while running, one-cycle done pulse.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = cntWidth(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    serialState_e     state_q;
    logic [WIDTH-1:0] aSh_q;
    logic [WIDTH-1:0] bSh_q;
    logic [WIDTH-1:0] resSh_q;
    logic [WIDTH-1:0] resSh_d;
    logic [WIDTH-1:0] diff_q;
    logic             brw_q;
    logic             bout_q;
    logic [CNT_W-1:0] count_q;
    logic             fsDiff;
    logic             fsBout;

    full_subtractor u_fs (
        .a_i    (aSh_q[0]),
        .b_i    (bSh_q[0]),
        .bin_i  (brw_q),
        .diff_o (fsDiff),
        .bout_o (fsBout)
    );

    // New result bit enters at the MSB so bit 0 ends up at the LSB after WIDTH shifts.
    always_comb begin
        resSh_d            = resSh_q >> 1;
        resSh_d[WIDTH-1]   = fsDiff;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            aSh_q   <= '0;
            bSh_q   <= '0;
            resSh_q <= '0;
            diff_q  <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            count_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        aSh_q   <= a;
                        bSh_q   <= b;
                        brw_q   <= bin;
                        count_q <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    aSh_q   <= aSh_q >> 1;
                    bSh_q   <= bSh_q >> 1;
                    brw_q   <= fsBout;
                    resSh_q <= resSh_d;
                    count_q <= count_q + CNT_W'(1);
                    // Results are published only here, so they stay stable through the next run.
                    if (count_q == LAST_BIT) begin
                        diff_q  <= resSh_d;
                        bout_q  <= fsBout;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1,
// compared against plain-arithmetic a - b - bin.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       bin8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       bout8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       bin1;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       bout1;

    int checks;
    int errors;

    logic [7:0] heldDiff8;
    logic       heldBout8;
    logic [0:0] heldDiff1;
    logic       heldBout1;

    time doneTimeA;
    time doneTimeB;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .bout  (bout8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .bin   (bin1),
        .busy  (busy1),
        .done  (done1),
        .diff  (diff1),
        .bout  (bout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one 8-bit request on a falling edge; the next rising edge accepts it.
    task automatic applyStimulus(input logic [7:0] ia, input logic [7:0] ib, input logic ibin);
        @(negedge clk);
        start8 = 1'b1;
        a8     = ia;
        b8     = ib;
        bin8   = ibin;
    endtask

    // Full 8-bit operation: cycle-by-cycle handshake checks, then result vs model.
    task automatic runOp8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                          input bit holdStart, output time doneT);
        logic [8:0] model;
        model = {1'b0, ia} - {1'b0, ib} - {8'd0, ibin};
        doneT = 0;
        applyStimulus(ia, ib, ibin);
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            checkOutput("busy8", {63'd0, busy8}, {63'd0, (n <= 8)});
            checkOutput("done8", {63'd0, done8}, {63'd0, (n == 9)});
            if (n <= 8) begin
                checkOutput("diff8_held", {56'd0, diff8}, {56'd0, heldDiff8});
                checkOutput("bout8_held", {63'd0, bout8}, {63'd0, heldBout8});
            end else begin
                doneT = $time;
                checkOutput("diff8", {56'd0, diff8}, {56'd0, model[7:0]});
                checkOutput("bout8", {63'd0, bout8}, {63'd0, model[8]});
            end
            if (holdStart && n <= 8) begin
                a8   = 8'($urandom);
                b8   = 8'($urandom);
                bin8 = 1'($urandom);
            end else begin
                start8 = 1'b0;
            end
        end
        heldDiff8 = model[7:0];
        heldBout8 = model[8];
    endtask

    task automatic runOp1(input logic ia, input logic ib, input logic ibin);
        logic [1:0] model;
        model = {1'b0, ia} - {1'b0, ib} - {1'b0, ibin};
        @(negedge clk);
        start1 = 1'b1;
        a1     = ia;
        b1     = ib;
        bin1   = ibin;
        @(negedge clk);
        start1 = 1'b0;
        checkOutput("busy1", {63'd0, busy1}, 64'd1);
        checkOutput("diff1_held", {63'd0, diff1}, {63'd0, heldDiff1});
        @(negedge clk);
        checkOutput("done1", {63'd0, done1}, 64'd1);
        checkOutput("busy1_off", {63'd0, busy1}, 64'd0);
        checkOutput("diff1", {63'd0, diff1}, {63'd0, model[0]});
        checkOutput("bout1", {63'd0, bout1}, {63'd0, model[1]});
        heldDiff1 = model[0];
        heldBout1 = model[1];
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        heldDiff8 = '0;
        heldBout8 = 1'b0;
        heldDiff1 = '0;
        heldBout1 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        rst_n  = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_busy", {63'd0, busy8}, 64'd0);
        checkOutput("rst_done", {63'd0, done8}, 64'd0);
        checkOutput("rst_diff", {56'd0, diff8}, 64'd0);
        checkOutput("rst_bout", {63'd0, bout8}, 64'd0);
        rst_n = 1'b1;

        $display("[TB] directed 8-bit operations");
        runOp8(8'd5, 8'd3, 1'b0, 1'b0, doneTimeA);
        runOp8(8'd3, 8'd5, 1'b0, 1'b0, doneTimeA);
        runOp8(8'd0, 8'd0, 1'b1, 1'b0, doneTimeA);

        // Back-to-back at the earliest restart: done pulses 10 cycles apart.
        runOp8(8'hFF, 8'h00, 1'b0, 1'b0, doneTimeA);
        runOp8(8'h80, 8'h80, 1'b0, 1'b0, doneTimeB);
        checkOutput("done_spacing", 64'(doneTimeB - doneTimeA), 64'd100);

        $display("[TB] start held high during RUN");
        runOp8(8'h4C, 8'h9A, 1'b1, 1'b1, doneTimeA);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checkOutput("no_extra_done", {63'd0, done8}, 64'd0);
            checkOutput("no_extra_busy", {63'd0, busy8}, 64'd0);
        end

        $display("[TB] reset during RUN");
        applyStimulus(8'h10, 8'h01, 1'b0);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mid_busy", {63'd0, busy8}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", {63'd0, busy8}, 64'd0);
        checkOutput("abort_diff", {56'd0, diff8}, 64'd0);
        checkOutput("abort_bout", {63'd0, bout8}, 64'd0);
        heldDiff8 = '0;
        heldBout8 = 1'b0;
        heldDiff1 = '0;
        heldBout1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            checkOutput("abort_no_done", {63'd0, done8}, 64'd0);
        end
        runOp8(8'h10, 8'h01, 1'b0, 1'b0, doneTimeA);

        $display("[TB] random 8-bit operations");
        for (int i = 0; i < 150; i++) begin
            runOp8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, doneTimeA);
        end

        $display("[TB] WIDTH=1 operations");
        runOp1(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            runOp1(1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
